mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum grant-hold cycles without an acknowledge (used only with MEM_ARBITER_TIMEOUT_EN).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: req  input  4  per-requester request; requester i holds req[i] high until its transaction completes.
REQ-005 Port: mem_ack  input  1  shared-resource completion pulse for the current owner.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 Port: sel  output  2  registered owner index; drives the 4:1 select of the shared address/data muxes.
REQ-008 Port: busy  output  1  high while a grant is held.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 In IDLE with req nonzero, the block SHALL pick the first set req bit at or after rr_ptr, wrapping 3->0, and enter GRANT next cycle with gnt one-hot, sel = index, busy = 1.
REQ-012 Grant latency SHALL be exactly one cycle from the IDLE cycle in which req is sampled.
REQ-013 In IDLE with req = 0, outputs SHALL stay gnt = 0, busy = 0, sel unchanged.
REQ-014 In GRANT, gnt and sel SHALL remain constant; requests from other requesters SHALL be ignored.
REQ-015 On mem_ack in GRANT, the block SHALL return to IDLE next cycle with gnt = 0, and rr_ptr SHALL become (owner+1) mod 4.
REQ-016 If the owner's req drops in GRANT without mem_ack, the block SHALL treat it as abort: same transition and rr_ptr update as REQ-015.
REQ-017 mem_ack and owner req-drop in the same cycle SHALL be handled as a single completion.
REQ-018 mem_ack while in IDLE SHALL be ignored.
REQ-019 Every grant SHALL be followed by at least one IDLE cycle (no back-to-back grants); a requester waits at most 3 other grants.

Reset
REQ-020 While rst_n = 0: state = IDLE, gnt = 0, sel = 0, busy = 0, timeout = 0, rr_ptr = 0, watchdog counter = 0.
REQ-021 Reset asserted mid-GRANT SHALL drop the grant immediately (asynchronously); after release, arbitration restarts from requester 0.

Configuration
REQ-022 Macro MEM_ARBITER_TIMEOUT_EN defined: a counter SHALL clear on GRANT entry, increment each GRANT cycle, and when it reaches TIMEOUT without mem_ack the block SHALL go to IDLE, pulse timeout for one cycle and update rr_ptr as REQ-015.
REQ-023 mem_ack in the same cycle the count reaches TIMEOUT SHALL count as normal completion, no timeout pulse.
REQ-024 Macro undefined: no counter SHALL be built, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Structure
REQ-025 A shared package SHALL hold the FSM state type (IDLE, GRANT), requester count constant (4) and select width constant (2).
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs req, rr_ptr; outputs valid, index).

Verification
REQ-027 Reset, then req = 4'b0001 -> gnt = 4'b0001, sel = 0, busy = 1 one cycle later; mem_ack -> gnt = 0 next cycle.
REQ-028 req = 4'b1111 held, ack each grant -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-029 Owner 2 granted, rr_ptr = 3, req = 4'b0101 after owner drops -> next grant to requester 0 (wrap).
REQ-030 Owner 1 drops req with no ack -> gnt = 0 next cycle, next grant to a requester other than 1 if one is pending.
REQ-031 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT = 4, no ack -> grant revoked after 4 GRANT cycles, timeout pulses once; ack on cycle 4 -> no pulse.
REQ-032 rst_n asserted low mid-GRANT -> gnt = 0, sel = 0 without waiting for a clock edge; first grant after reset goes to the lowest-index active requester.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and sizes for the memory arbiter.
// Imported by mem_arbiter and rr_picker.
package mem_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request
// at or after i_rr_ptr, wrapping from the top index back to 0.
module rr_picker
  import mem_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  i_req,
  input  logic [SEL_W-1:0] i_rr_ptr,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_index
);

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from far to near so the nearest hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = i_rr_ptr;
    w_idx   = i_rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = i_rr_ptr + SEL_W'(k);
      if (i_req[w_idx]) begin
        o_valid = 1'b1;
        o_index = w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: 4-requester round-robin owner arbiter for a shared memory.
// Define MEM_ARBITER_TIMEOUT_EN to build the grant-hold watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             mem_ack,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_timeout;
  logic             w_to_nxt;
  logic             w_pick_vld;
  logic [SEL_W-1:0] w_pick_idx;
  logic             w_done;
  logic             w_rel;

  rr_picker u_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_vld),
    .o_index  (w_pick_idx)
  );

  // Ack and owner abort collapse into one completion event.
  assign w_done = mem_ack | ~req[r_sel];

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_wd_cnt;
  logic [CNT_W-1:0] w_wd_nxt;
  logic             w_wd_hit;

  assign w_wd_hit = (r_wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wd_cnt <= '0;
    else        r_wd_cnt <= w_wd_nxt;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_ptr_nxt   = r_rr_ptr;
    w_to_nxt    = 1'b0;
    w_rel       = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    w_wd_nxt    = r_wd_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        w_gnt_nxt  = '0;
        w_busy_nxt = 1'b0;
        if (w_pick_vld) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = NREQ'(1) << w_pick_idx;
          w_sel_nxt   = w_pick_idx;
          w_busy_nxt  = 1'b1;
`ifdef MEM_ARBITER_TIMEOUT_EN
          w_wd_nxt    = '0;
`endif
        end
      end
      GRANT: begin
        if (w_done) begin
          w_rel = 1'b1;
`ifdef MEM_ARBITER_TIMEOUT_EN
        end else if (w_wd_hit) begin
          w_rel    = 1'b1;
          w_to_nxt = 1'b1;
        end else begin
          w_wd_nxt = r_wd_cnt + CNT_W'(1);
`endif
        end
        if (w_rel) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_to_nxt;
      r_rr_ptr  <= w_ptr_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Covers the watchdog when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       mem_ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  int n_cmp;
  int n_err;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mem_ack (mem_ack),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [3:0] e;
    e = 4'b0001 << idx;
    chk({tag, "_gnt"}, {4'b0, gnt}, {4'b0, e});
    chk({tag, "_sel"}, {6'b0, sel}, 8'(idx));
    chk({tag, "_busy"}, {7'b0, busy}, 8'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, {4'b0, gnt}, 8'h0);
    chk({tag, "_busy"}, {7'b0, busy}, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    mem_ack = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle("rst");
    chk("rst_sel", {6'b0, sel}, 8'd0);
    chk("rst_to", {7'b0, timeout}, 8'd0);
    rst_n = 1'b1;

    // Single requester, one-cycle latency, ack release
    req = 4'b0001;
    tick();
    chk_grant("single", 0);
    mem_ack = 1'b1;
    tick();
    chk_idle("single_ack");
    mem_ack = 1'b0;
    req     = 4'b0000;
    tick();
    chk_idle("idle_noreq");
    chk("idle_sel_hold", {6'b0, sel}, 8'd0);

    // Full round robin from pointer 0
    do_reset();
    req = 4'b1111;
    tick();
    chk_grant("rr_g0", 0);
    tick();
    chk_grant("rr_hold", 0);
    mem_ack = 1'b1;
    tick();
    chk_idle("rr_i0");
    mem_ack = 1'b0;
    tick();
    chk_grant("rr_g1", 1);
    mem_ack = 1'b1;
    tick();
    chk_idle("rr_i1");
    mem_ack = 1'b0;
    tick();
    chk_grant("rr_g2", 2);
    mem_ack = 1'b1;
    tick();
    chk_idle("rr_i2");
    mem_ack = 1'b0;
    tick();
    chk_grant("rr_g3", 3);
    mem_ack = 1'b1;
    tick();
    chk_idle("rr_i3");
    mem_ack = 1'b0;
    tick();
    chk_grant("rr_g4", 0);
    mem_ack = 1'b1;
    tick();
    chk_idle("rr_i4");
    mem_ack = 1'b0;
    req     = 4'b0000;

    // Owner 2 aborts; pointer 3 wraps to requester 0
    req = 4'b0100;
    tick();
    chk_grant("wrap_own2", 2);
    req = 4'b0000;
    tick();
    chk_idle("wrap_drop");
    req = 4'b0101;
    tick();
    chk_grant("wrap_g0", 0);
    mem_ack = 1'b1;
    tick();
    chk_idle("wrap_ack");
    mem_ack = 1'b0;
    req     = 4'b0000;

    // Owner 1 aborts, pending requester 3 gets next grant
    req = 4'b0010;
    tick();
    chk_grant("abort_own1", 1);
    req = 4'b1000;
    tick();
    chk_idle("abort_drop");
    tick();
    chk_grant("abort_g3", 3);

    // Ack and drop together form one completion; pointer ends at 0
    mem_ack = 1'b1;
    req     = 4'b0000;
    tick();
    chk_idle("both_rel");
    tick();
    chk_idle("ack_in_idle");
    mem_ack = 1'b0;
    req     = 4'b1111;
    tick();
    chk_grant("both_next", 0);
    mem_ack = 1'b1;
    req     = 4'b0000;
    tick();
    chk_idle("both_next_rel");
    mem_ack = 1'b0;

`ifdef MEM_ARBITER_TIMEOUT_EN
    // Watchdog revokes after four grant cycles
    req = 4'b0100;
    tick();
    chk_grant("wd_g", 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_grant("wd_hold", 2);
      chk("wd_hold_to", {7'b0, timeout}, 8'd0);
    end
    tick();
    chk_idle("wd_rev");
    chk("wd_pulse", {7'b0, timeout}, 8'd1);
    tick();
    chk("wd_pulse_end", {7'b0, timeout}, 8'd0);
    chk_grant("wd_regrant", 2);
    for (int i = 0; i < 3; i++) tick();
    mem_ack = 1'b1;
    tick();
    chk_idle("wd_ack4");
    chk("wd_ack4_to", {7'b0, timeout}, 8'd0);
    mem_ack = 1'b0;
    req     = 4'b0000;
    tick();
    chk("wd_ack4_to2", {7'b0, timeout}, 8'd0);
`else
    // No watchdog: grant held indefinitely
    req = 4'b0100;
    tick();
    chk_grant("nowd_g", 2);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nowd_hold", {4'b0, gnt}, 8'h04);
      chk("nowd_to", {7'b0, timeout}, 8'd0);
    end
    mem_ack = 1'b1;
    tick();
    chk_idle("nowd_rel");
    mem_ack = 1'b0;
    req     = 4'b0000;
`endif

    // Asynchronous reset mid-grant
    req = 4'b1000;
    tick();
    chk_grant("areset_pre", 3);
    rst_n = 1'b0;
    #2;
    chk_idle("areset_now");
    chk("areset_sel", {6'b0, sel}, 8'd0);
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    chk_grant("areset_first", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
